// File: rtl/inst_fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM state encoding and
// the buffer-space rule that gates a new memory request.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;

  // A reply always has somewhere to land: either slot of the two-deep buffer.
  function automatic logic can_issue(input logic out_valid, input logic pend_valid);
    return !out_valid || !pend_valid;
  endfunction

endpackage

// File: rtl/inst_fetch_buf.sv
// Two-deep fetch buffer: decoder-facing output register plus one pending slot.
// Keeps the valid/ready handshake stable independent of the fetch FSM.
module inst_fetch_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic [ADDR_W-1:0] load_pc_i,
  input  logic              deq_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic              pend_valid_o
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              consume;

  assign consume = out_valid_q && deq_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_pc_d     = out_pc_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_pc_d    = pend_pc_q;
    if (flush_i) begin
      // Data is left in place; only the valid bits are killed.
      out_valid_d  = 1'b0;
      pend_valid_d = 1'b0;
    end else begin
      if (consume) out_valid_d = 1'b0;
      if (consume && pend_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = pend_data_q;
        out_pc_d     = pend_pc_q;
        pend_valid_d = 1'b0;
      end
      if (load_i) begin
        if (!out_valid_q || consume) begin
          out_valid_d = 1'b1;
          out_data_d  = load_data_i;
          out_pc_d    = load_pc_i;
        end else begin
          pend_valid_d = 1'b1;
          pend_data_d  = load_data_i;
          pend_pc_d    = load_pc_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_pc_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_pc_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_pc_q     <= out_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_pc_o     = out_pc_q;
  assign pend_valid_o = pend_valid_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: one outstanding imem read at a time, two-deep reply buffer,
// flush drops wrong-path replies. FETCH_STALL_CNT_EN enables the starvation counter.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_adv,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              dec_ready,
  output logic [31:0]       stall_cnt
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              drop_q, drop_d;
  logic              pend_valid;
  logic              grant;
  logic              out_free;
  logic              buf_load;

  assign grant    = imem_req && imem_gnt;
  assign out_free = !inst_valid || dec_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IF_IDLE;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    if (grant) req_pc_d = pc;
    unique case (state_q)
      IF_IDLE: state_d = IF_REQ;
      IF_REQ: begin
        if (grant) begin
          state_d = IF_WAIT;
          drop_d  = flush;
        end
      end
      IF_WAIT: begin
        if (imem_rvalid) begin
          // A reply landing with a flush is wrong-path too, so never wait for another.
          drop_d = 1'b0;
          if (!drop_q && !flush && !out_free) state_d = IF_HOLD;
          else                                state_d = IF_REQ;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      IF_HOLD: if (flush || dec_ready) state_d = IF_REQ;
      default: state_d = IF_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == IF_REQ) && can_issue(inst_valid, pend_valid);
    imem_addr = pc;
    pc_adv    = grant;
    buf_load  = (state_q == IF_WAIT) && imem_rvalid && !drop_q && !flush;
  end

  inst_fetch_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .load_i      (buf_load),
    .load_data_i (imem_rdata),
    .load_pc_i   (req_pc_q),
    .deq_i       (dec_ready),
    .out_valid_o (inst_valid),
    .out_data_o  (inst),
    .out_pc_o    (inst_pc),
    .pend_valid_o(pend_valid)
  );

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          stall_q <= '0;
    else if (!inst_valid) stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized traffic against a
// transaction-level model (live-fetch queue, one outstanding read, flush kills).
module tb_inst_fetch;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] pc;
  logic          pc_adv, flush, imem_req, imem_gnt, imem_rvalid;
  logic [AW-1:0] imem_addr, inst_pc;
  logic [DW-1:0] imem_rdata, inst;
  logic          inst_valid, dec_ready;
  logic [31:0]   stall_cnt;

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_adv(pc_adv), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .dec_ready(dec_ready), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int nchk = 0, npass = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
  endtask

  // knobs
  int gnt_pct = 100, rdy_pct = 100, flush_pct = 0, lat_min = 1, lat_max = 1;
  int flush_at = -1;
  logic [31:0] flush_tgt = '0;

  // memory model
  bit [31:0] imem [bit [31:0]];
  bit        rv_pend = 0;
  int        rv_cnt = 0;
  logic [31:0] rv_addr = '0;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (imem.exists(a)) return imem[a];
    return (a * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  // reference model: delivered-but-unconsumed fetch addresses, one in-flight read
  logic [31:0] q[$];
  logic [31:0] seen[$];
  bit          out_busy = 0, out_killed = 0, started = 0;
  logic [31:0] out_addr = '0, pc_nxt = '0, exp_stall = '0;
  int          cyc = 0, first_vld = -1, consumed = 0;

  task automatic drive();
    bit f;
    imem_gnt  = ($urandom_range(99) < gnt_pct);
    dec_ready = ($urandom_range(99) < rdy_pct);
    f = (cyc == flush_at) || ($urandom_range(99) < flush_pct);
    if (f && flush_pct > 0) flush_tgt = $urandom_range(255);
    flush = f;
    pc = pc_nxt;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (rv_pend) begin
      if (rv_cnt > 0) rv_cnt--;
      if (rv_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word(rv_addr);
      end
    end
  endtask

  task automatic sample();
    bit exp_req, take;
    exp_req = started && !out_busy && (q.size() < 2);
    take    = exp_req && imem_gnt;
    chk("imem_req", imem_req, exp_req);
    if (imem_req) chk("imem_addr", imem_addr, pc);
    chk("pc_adv", pc_adv, take);
    chk("inst_valid", inst_valid, q.size() > 0);
    if (inst_valid && q.size() > 0) begin
      chk("inst_pc", inst_pc, q[0]);
      chk("inst", inst, word(q[0]));
    end
    chk("stall_cnt", stall_cnt, exp_stall);
    if (inst_valid && first_vld < 0) first_vld = cyc;
`ifdef FETCH_STALL_CNT_EN
    if (q.size() == 0) exp_stall++;
`endif
    if (flush) begin
      q.delete();
      if (out_busy) out_killed = 1;
    end else if (q.size() > 0 && dec_ready) begin
      seen.push_back(q.pop_front());
      consumed++;
    end
    if (imem_rvalid) rv_pend = 0;
    if (imem_rvalid && out_busy) begin
      if (!out_killed && !flush) q.push_back(out_addr);
      out_busy = 0;
    end
    if (take) begin
      out_busy = 1; out_addr = pc; out_killed = flush;
    end
    if (imem_req && imem_gnt) begin
      rv_pend = 1; rv_addr = pc; rv_cnt = $urandom_range(lat_max, lat_min);
    end
    pc_nxt = flush ? flush_tgt : (take ? pc + 32'd1 : pc);
    started = 1;
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    sample();
  endtask

  task automatic do_reset(input logic [31:0] pc0, input bit stray);
    rst_n = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_adv", pc_adv, 0);
    chk("rst_vld", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_ipc", inst_pc, 0);
    chk("rst_stall", stall_cnt, 0);
    q.delete(); seen.delete();
    out_busy = 0; out_killed = 0; started = 0; exp_stall = '0;
    cyc = 0; first_vld = -1; consumed = 0; flush_at = -1; pc_nxt = pc0;
    rv_pend = stray; rv_cnt = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic knobs(input int g, input int r, input int f, input int lmin, input int lmax);
    gnt_pct = g; rdy_pct = r; flush_pct = f; lat_min = lmin; lat_max = lmax;
  endtask

  logic [31:0] s0;

  initial begin
    pc = '0; flush = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; dec_ready = 0;
    @(posedge clk);

    // streaming: first instruction 3 cycles after release, in order
    knobs(100, 100, 0, 1, 1);
    do_reset(32'd0, 0);
    repeat (8) step();
    chk("t1_first_vld", first_vld, 3);
    chk("t1_count", seen.size() >= 3, 1);
    for (int i = 0; i < 3; i++) if (i < seen.size()) chk("t1_order", seen[i], i);

    // grant withheld: request held at pc=5
    knobs(0, 100, 0, 1, 1);
    do_reset(32'd5, 0);
    step();
    s0 = stall_cnt;
    repeat (4) begin
      step();
      chk("t2_req", imem_req, 1);
      chk("t2_addr", imem_addr, 5);
      chk("t2_adv", pc_adv, 0);
      chk("t2_vld", inst_valid, 0);
    end
`ifdef FETCH_STALL_CNT_EN
    chk("t2_stall", stall_cnt - s0, 4);
`else
    chk("t2_stall", stall_cnt, 0);
`endif

    // decoder back-pressure: second reply parks in pending
    imem[0] = 32'h00A00093; imem[1] = 32'h00100113;
    knobs(100, 0, 0, 1, 1);
    do_reset(32'd0, 0);
    repeat (5) step();
    chk("t3_hold_vld", inst_valid, 1);
    chk("t3_hold_inst", inst, 32'h00A00093);
    chk("t3_hold_req", imem_req, 0);
    rdy_pct = 100;
    step();
    chk("t3_consume_inst", inst, 32'h00A00093);
    step();
    chk("t3_promote_inst", inst, 32'h00100113);
    chk("t3_promote_pc", inst_pc, 1);
    chk("t3_new_req", imem_req, 1);
    imem.delete();

    // flush while waiting for pc=7
    imem[7] = 32'hDEADBEEF;
    knobs(100, 100, 0, 2, 2);
    do_reset(32'd7, 0);
    flush_at = 2; flush_tgt = 32'h40;
    step(); step(); step();
    chk("t4_drop_vld", inst_valid, 0);
    step();
    chk("t4_vld", inst_valid, 0);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 32'h40);
    repeat (4) step();
    chk("t4_tgt_seen", seen.size() > 0, 1);
    if (seen.size() > 0) chk("t4_tgt_pc", seen[0], 32'h40);
    imem.delete();

    // flush together with grant
    knobs(100, 100, 0, 1, 1);
    do_reset(32'd0, 0);
    flush_at = 1; flush_tgt = 32'h80;
    step();
    chk("t5_adv", pc_adv, 1);
    step();
    chk("t5_drop_vld", inst_valid, 0);
    step();
    chk("t5_vld", inst_valid, 0);
    chk("t5_addr", imem_addr, 32'h80);

    // reset mid-WAIT with a stray reply after release
    knobs(100, 100, 0, 3, 3);
    do_reset(32'd0, 0);
    step(); step();
    gnt_pct = 0;
    do_reset(32'd0, 1);
    repeat (4) begin
      step();
      chk("t6_vld", inst_valid, 0);
    end

    // randomized traffic
    knobs(70, 60, 4, 1, 3);
    do_reset(32'd0, 0);
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 499)
        knobs($urandom_range(30, 100), $urandom_range(20, 100), $urandom_range(0, 8), 1, $urandom_range(1, 4));
      step();
    end
    chk("rnd_live", consumed > 100, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
